// File: rtl/key_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module   : key_entry_buffer
// Purpose  : Collects scan-code symbols from the PS/2 decoder into a
//            DEPTH-symbol shift buffer with backspace, clear, overflow
//            detection and an enter-triggered commit. The commit is offered
//            to the display/ALU stage over a valid/ready handshake.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            key_strobe          - one-cycle pulse, key_code/key_break valid
//            key_code            - symbol from the decoder
//            key_break           - release event, never inserted
//            buf_data            - live buffer, newest symbol in the low bits
//            buf_count, buf_full - occupancy, full flag
//            commit_data         - snapshot taken on enter
//            commit_valid        - snapshot valid, held until accepted
//            commit_ready        - consumer accept
//            key_dropped         - one-cycle pulse, a make key was discarded
// Options  : KEY_ENTRY_REPEAT_FILTER_EN - when defined, a data symbol equal
//            to the last processed one is ignored until a break strobe
//            (suppresses typematic auto-repeat).
// Notes    : DEPTH must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module key_entry_buffer #(
  parameter int               SYM_W      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [SYM_W-1:0] CODE_BKSP  = 8'h66,
  parameter logic [SYM_W-1:0] CODE_ENTER = 8'h5A,
  parameter logic [SYM_W-1:0] CODE_CLEAR = 8'h76
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_strobe,
  input  logic [SYM_W-1:0]           key_code,
  input  logic                       key_break,
  output logic [SYM_W*DEPTH-1:0]     buf_data,
  output logic [$clog2(DEPTH+1)-1:0] buf_count,
  output logic                       buf_full,
  output logic [SYM_W*DEPTH-1:0]     commit_data,
  output logic                       commit_valid,
  input  logic                       commit_ready,
  output logic                       key_dropped
);

  localparam int               BUF_W   = SYM_W * DEPTH;
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_ENTRY  = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUF_W-1:0]   cdata_q, cdata_d;
  logic               cvalid_q, cvalid_d;
  logic               drop_q, drop_d;

  logic               accept;
  logic               is_bksp;
  logic               is_enter;
  logic               is_clear;
  logic               is_ctrl;
  logic               repeat_hit;

  assign accept   = key_strobe & ~key_break;
  assign is_bksp  = (key_code == CODE_BKSP);
  assign is_enter = (key_code == CODE_ENTER);
  assign is_clear = (key_code == CODE_CLEAR);
  assign is_ctrl  = is_bksp | is_enter | is_clear;

`ifdef KEY_ENTRY_REPEAT_FILTER_EN
  // Last data symbol processed in ENTRY; flt_armed_q high means repeats of
  // it are currently being suppressed. Any break strobe lifts suppression.
  logic [SYM_W-1:0] flt_sym_q, flt_sym_d;
  logic             flt_armed_q, flt_armed_d;

  assign repeat_hit = flt_armed_q & (key_code == flt_sym_q);

  always_comb begin
    flt_sym_d   = flt_sym_q;
    flt_armed_d = flt_armed_q;
    if (key_strobe & key_break) begin
      flt_armed_d = 1'b0;
    end else if (accept && (state_q == ST_ENTRY)) begin
      if (is_ctrl) begin
        flt_sym_d   = '0;
        flt_armed_d = 1'b0;
      end else if (!repeat_hit) begin
        flt_sym_d   = key_code;
        flt_armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_sym_q   <= '0;
      flt_armed_q <= 1'b0;
    end else begin
      flt_sym_q   <= flt_sym_d;
      flt_armed_q <= flt_armed_d;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    cdata_d  = cdata_q;
    cvalid_d = cvalid_q;
    drop_d   = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (accept) begin
          if (is_clear) begin
            buf_d = '0;
            cnt_d = '0;
          end else if (is_bksp) begin
            if (cnt_q != '0) begin
              buf_d = buf_q >> SYM_W;
              cnt_d = cnt_q - CNT_ONE;
            end
          end else if (is_enter) begin
            if (cnt_q != '0) begin
              cdata_d  = buf_q;
              cvalid_d = 1'b1;
              buf_d    = '0;
              cnt_d    = '0;
              state_d  = ST_COMMIT;
            end
          end else if (!repeat_hit) begin
            if (cnt_q != CNT_MAX) begin
              buf_d = {buf_q[BUF_W-SYM_W-1:0], key_code};
              cnt_d = cnt_q + CNT_ONE;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
      end
      ST_COMMIT: begin
        // Nothing edits the buffer while a snapshot is outstanding, even in
        // the cycle the handshake completes.
        if (accept) begin
          drop_d = 1'b1;
        end
        if (cvalid_q & commit_ready) begin
          cvalid_d = 1'b0;
          state_d  = ST_ENTRY;
        end
      end
      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ENTRY;
      buf_q    <= '0;
      cnt_q    <= '0;
      cdata_q  <= '0;
      cvalid_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      cdata_q  <= cdata_d;
      cvalid_q <= cvalid_d;
      drop_q   <= drop_d;
    end
  end

  assign buf_data     = buf_q;
  assign buf_count    = cnt_q;
  assign buf_full     = (cnt_q == CNT_MAX);
  assign commit_data  = cdata_q;
  assign commit_valid = cvalid_q;
  assign key_dropped  = drop_q;

endmodule
`default_nettype wire
